// File: rtl/aes_mode_engine.sv
// Block-cipher mode engine: runs one block at a time through an iterative AES core
// and applies ECB, CBC (enc/dec) or CTR chaining around it.

module aes_mode_engine #(
    parameter int                 BLOCK_W = 128,
    parameter int                 CTR_W   = 32,
    parameter logic [BLOCK_W-1:0] IV      = BLOCK_W'(1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_enc_dec,
    input  logic [BLOCK_W-1:0] cfg_iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               core_start,
    output logic               core_enc_dec,
    output logic [BLOCK_W-1:0] core_block_in,
    input  logic [BLOCK_W-1:0] core_block_out,
    input  logic               core_valid,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ECB = 2'b00;
    localparam logic [1:0] MODE_CBC = 2'b01;
    localparam logic [1:0] MODE_CTR = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    state_t             state;
    state_t             state_next;
    logic [1:0]         mode;
    logic               enc_dec;
    logic [BLOCK_W-1:0] chain;
    logic [BLOCK_W-1:0] data_q;
    logic               accept;
    logic               finish;
    logic [BLOCK_W-1:0] core_in_next;
    logic [BLOCK_W-1:0] result_next;
    logic [BLOCK_W-1:0] chain_next;

    // Only the low CTR_W bits count; the upper part of the counter block is a fixed nonce.
    function automatic logic [BLOCK_W-1:0] ctr_inc(input logic [BLOCK_W-1:0] blk);
        logic [BLOCK_W-1:0] r;
        r              = blk;
        r[CTR_W-1:0]   = blk[CTR_W-1:0] + CTR_W'(1);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = !init;
                if (in_valid && !init) begin
                    state_next = START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (core_valid) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept       = in_valid && in_ready;
    assign finish       = (state == WAIT) && core_valid;
    assign core_enc_dec = (mode == MODE_CTR) ? 1'b1 : enc_dec;

    // core_in_next is registered on the accept edge, so it reads in_data where
    // the chaining equations name data_q (both hold the same block then).
    always_comb begin
        core_in_next = in_data;
        result_next  = core_block_out;
        chain_next   = chain;
        case (mode)
            MODE_CBC: begin
                if (enc_dec) begin
                    core_in_next = in_data ^ chain;
                    chain_next   = core_block_out;
                end else begin
                    result_next  = core_block_out ^ chain;
                    chain_next   = data_q;
                end
            end
            MODE_CTR: begin
                core_in_next = chain;
                result_next  = core_block_out ^ data_q;
                chain_next   = ctr_inc(chain);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode          <= MODE_ECB;
            enc_dec       <= 1'b1;
            chain         <= IV;
            data_q        <= '0;
            core_block_in <= '0;
            out_data      <= '0;
            err           <= 1'b0;
        end else begin
            if (init) begin
                if (state != IDLE || cfg_mode == MODE_RSV) begin
                    err <= 1'b1;
                end else begin
                    mode    <= cfg_mode;
                    enc_dec <= cfg_enc_dec;
                    chain   <= cfg_iv;
                    err     <= 1'b0;
                end
            end
            if (accept) begin
                data_q        <= in_data;
                core_block_in <= core_in_next;
            end
            // A core_valid seen outside WAIT is a stale result and is dropped.
            if (finish) begin
                out_data <= result_next;
                chain    <= chain_next;
            end
        end
    end

endmodule

// File: tb/tb_aes_mode_engine.sv
// Bench for aes_mode_engine: a fixed-latency core stand-in, a scoreboard of expected
// output blocks, a table of single-block messages and hand-written corner sequences.

module tb_aes_mode_engine;

    localparam logic [127:0] IV_RST   = 128'h1;
    localparam logic [127:0] KEY      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AES_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int           CORE_LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         init;
    logic [1:0]   cfg_mode;
    logic         cfg_enc_dec;
    logic [127:0] cfg_iv;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         core_start;
    logic         core_enc_dec;
    logic [127:0] core_block_in;
    logic [127:0] core_block_out;
    bit           core_valid;
    logic         busy;
    logic         err;

    aes_mode_engine dut (
        .clk            (clk),
        .rst            (rst),
        .init           (init),
        .cfg_mode       (cfg_mode),
        .cfg_enc_dec    (cfg_enc_dec),
        .cfg_iv         (cfg_iv),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .core_start     (core_start),
        .core_enc_dec   (core_enc_dec),
        .core_block_in  (core_block_in),
        .core_block_out (core_block_out),
        .core_valid     (core_valid),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Core stand-in: the FIPS-197 example pair maps exactly; any other block goes
    // through an invertible keyed rotation, which is all the mode logic depends on.
    function automatic logic [127:0] core_model(input bit enc, input logic [127:0] x);
        logic [127:0] t;
        if (enc) begin
            if (x == AES_PT) return AES_CT;
            t = x ^ KEY;
            return {t[114:0], t[127:115]};
        end else begin
            if (x == AES_CT) return AES_PT;
            t = {x[12:0], x[127:13]};
            return t ^ KEY;
        end
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [127:0] stub_blk;
    bit           stub_dir;
    int           stub_cnt;

    always @(posedge clk) begin
        core_valid <= 1'b0;
        if (core_start === 1'b1) begin
            stub_blk <= core_block_in;
            stub_dir <= core_enc_dec;
            stub_cnt <= CORE_LAT;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                core_valid     <= 1'b1;
                core_block_out <= core_model(stub_dir, stub_blk);
            end
        end
    end

    int           errors = 0;
    int           checks = 0;
    logic [127:0] exp_q[$];
    logic [127:0] start_in_q[$];
    bit           start_dir_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (core_start === 1'b1) begin
            start_in_q.push_back(core_block_in);
            start_dir_q.push_back(core_enc_dec);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: actual=%h required=no output", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic do_init(input logic [1:0] m, input bit ed, input logic [127:0] iv);
        @(negedge clk);
        init        = 1'b1;
        cfg_mode    = m;
        cfg_enc_dec = ed;
        cfg_iv      = iv;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d, input logic [127:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: actual=%b required=1", in_ready);
        end else begin
            exp_q.push_back(e);
            in_valid = 1'b1;
            in_data  = d;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_timeout: actual busy=%b pending=%0d required busy=0 pending=0",
                     busy, exp_q.size());
        end
    endtask

    typedef struct {
        logic [1:0]   mode;
        bit           ed;
        logic [127:0] iv;
        logic [127:0] din;
        logic [127:0] dout;
        bit           dir;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #300000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] iv_a, iv_b, iv_c, d_a, d_b, d_c;
        logic [127:0] p1, p2, c1, c2, iv_w, iv_n, d1, d2, o1, o2;
        logic [127:0] db, eb, xa, ya, pe, pf, cf, pg, pr, d0;
        bit           saw;
        int           n;

        rst         = 1'b0;
        init        = 1'b0;
        cfg_mode    = 2'b00;
        cfg_enc_dec = 1'b1;
        cfg_iv      = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_core_start", core_start, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_core_dir", core_enc_dec, 1'b1);
        check("rst_out_data", out_data, 128'h0);
        check("rst_core_in", core_block_in, 128'h0);
        check("rst_chain", dut.chain, IV_RST);

        // After reset with no init the engine runs ECB encrypt.
        d0 = rnd128();
        send_block(d0, core_model(1'b1, d0));
        wait_idle();

        iv_a = rnd128(); d_a = rnd128();
        iv_b = rnd128(); d_b = rnd128();
        iv_c = rnd128(); d_c = rnd128();
        vecs[0] = '{2'b00, 1'b1, 128'h0, AES_PT, AES_CT, 1'b1};
        vecs[1] = '{2'b00, 1'b0, 128'h0, AES_CT, AES_PT, 1'b0};
        vecs[2] = '{2'b01, 1'b1, iv_a, d_a, core_model(1'b1, d_a ^ iv_a), 1'b1};
        vecs[3] = '{2'b01, 1'b0, iv_b, d_b, core_model(1'b0, d_b) ^ iv_b, 1'b0};
        vecs[4] = '{2'b10, 1'b1, iv_c, d_c, core_model(1'b1, iv_c) ^ d_c, 1'b1};
        vecs[5] = '{2'b10, 1'b0, iv_c, d_c, core_model(1'b1, iv_c) ^ d_c, 1'b1};

        for (int i = 0; i < 6; i++) begin
            do_init(vecs[i].mode, vecs[i].ed, vecs[i].iv);
            start_in_q.delete();
            start_dir_q.delete();
            send_block(vecs[i].din, vecs[i].dout);
            wait_idle();
            check($sformatf("vec%0d_starts", i), 128'(start_dir_q.size()), 128'd1);
            if (start_dir_q.size() > 0)
                check1($sformatf("vec%0d_dir", i), start_dir_q[0], vecs[i].dir);
        end

        // CBC round trip with a zero IV: first ciphertext equals the ECB result.
        p1 = rnd128();
        p2 = rnd128();
        c1 = core_model(1'b1, p1);
        c2 = core_model(1'b1, p2 ^ c1);
        do_init(2'b01, 1'b1, 128'h0);
        send_block(p1, c1);
        send_block(p2, c2);
        wait_idle();
        do_init(2'b01, 1'b0, 128'h0);
        send_block(c1, p1);
        send_block(c2, p2);
        wait_idle();

        // CTR counter wrap in the low 32 bits.
        iv_w = 128'h0123456789abcdef00000000ffffffff;
        iv_n = 128'h0123456789abcdef0000000000000000;
        d1 = rnd128();
        d2 = rnd128();
        o1 = core_model(1'b1, iv_w) ^ d1;
        o2 = core_model(1'b1, iv_n) ^ d2;
        do_init(2'b10, 1'b1, iv_w);
        start_in_q.delete();
        start_dir_q.delete();
        send_block(d1, o1);
        send_block(d2, o2);
        wait_idle();
        check("ctr_starts", 128'(start_in_q.size()), 128'd2);
        if (start_in_q.size() == 2)
            check("ctr_blk2_core_in", start_in_q[1], iv_n);
        check("ctr_chain_after", dut.chain, 128'h0123456789abcdef0000000000000001);
        do_init(2'b10, 1'b0, iv_w);
        start_dir_q.delete();
        send_block(o1, d1);
        send_block(o2, d2);
        wait_idle();
        if (start_dir_q.size() == 2)
            check("ctr_dec_dir", 128'({start_dir_q[0], start_dir_q[1]}), 128'd3);
        else
            check("ctr_dec_starts", 128'(start_dir_q.size()), 128'd2);

        // Output back-pressure.
        do_init(2'b00, 1'b1, 128'h0);
        out_ready = 1'b0;
        db = rnd128();
        eb = core_model(1'b1, db);
        send_block(db, eb);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1("bp_out_valid_seen", out_valid, 1'b1);
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_data", out_data, eb);
            check("bp_ctl", 128'({out_valid, in_ready}), 128'b10);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release", 128'({busy, in_ready}), 128'b01);
        wait_idle();

        // Reserved mode: flagged, prior CBC config and chain kept.
        xa = rnd128();
        do_init(2'b01, 1'b1, xa);
        do_init(2'b11, 1'b0, rnd128());
        #1;
        check1("err_rsv", err, 1'b1);
        pe = rnd128();
        send_block(pe, core_model(1'b1, pe ^ xa));
        wait_idle();
        check1("err_sticky", err, 1'b1);

        // init while busy: flagged, chain and mode untouched.
        ya = rnd128();
        do_init(2'b01, 1'b1, ya);
        #1;
        check1("err_clear", err, 1'b0);
        pf = rnd128();
        cf = core_model(1'b1, pf ^ ya);
        send_block(pf, cf);
        @(negedge clk);
        init     = 1'b1;
        cfg_mode = 2'b00;
        cfg_iv   = rnd128();
        @(negedge clk);
        init = 1'b0;
        #1;
        check1("err_busy_init", err, 1'b1);
        wait_idle();
        pg = rnd128();
        send_block(pg, core_model(1'b1, pg ^ cf));
        wait_idle();

        // Reset while waiting on the core: block dropped, late core_valid ignored.
        do_init(2'b10, 1'b1, rnd128());
        pr = rnd128();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pr;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1) saw = 1'b1;
        end
        check1("rst_mid_no_out", saw, 1'b0);
        check("rst_mid_chain", dut.chain, IV_RST);
        check("rst_mid_ctl", 128'({in_ready, busy, err}), 128'b100);
        send_block(d0, core_model(1'b1, d0));
        wait_idle();

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
